// File: rtl/led_fade_pwm.sv
// led_fade_pwm: per-LED PWM driver with a fading
// comet trail behind the rotating LED pattern.
module led_fade_pwm #(
  parameter int NUM_LEDS     = 4,
  parameter int PWM_BITS     = 8,
  parameter int DECAY_FRAMES = 64,
  parameter int DECAY_STEP   = 32
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NUM_LEDS-1:0] PATTERN,
  input  logic                PATTERN_VALID,
  input  logic                ENABLE,
  output logic [NUM_LEDS-1:0] LED,
  output logic                FRAME_TICK
);

  localparam int DW = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;
  localparam int SW = PWM_BITS + 1;

  localparam logic [PWM_BITS-1:0] MAX   = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] LAST  = PWM_BITS'((1 << PWM_BITS) - 2);
  localparam logic [DW-1:0]       DLAST = DW'(DECAY_FRAMES - 1);
  localparam logic [SW-1:0]       STEP  = SW'(DECAY_STEP);

  logic [PWM_BITS-1:0] cnt;
  logic [DW-1:0]       dcnt;
  logic [NUM_LEDS-1:0] pat;
  logic [NUM_LEDS-1:0] eff;
  logic                wrap;
  logic                decay_tick;

  logic [PWM_BITS-1:0] target     [NUM_LEDS];
  logic [PWM_BITS-1:0] target_nxt [NUM_LEDS];
  logic [PWM_BITS-1:0] active     [NUM_LEDS];
  logic [SW-1:0]       diff       [NUM_LEDS];

  assign wrap       = (cnt == LAST);
  assign decay_tick = wrap && (dcnt == DLAST);
  assign eff        = PATTERN_VALID ? PATTERN : pat;

  // frame counter and decay-interval counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt  <= '0;
      dcnt <= '0;
    end else if (wrap) begin
      cnt  <= '0;
      dcnt <= (dcnt == DLAST) ? '0 : dcnt + 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

  // next brightness target: set bits pin to full,
  // cleared bits step down with saturation at zero
  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      diff[i]       = {1'b0, target[i]} - STEP;
      target_nxt[i] = target[i];
      if (decay_tick && !eff[i])
        target_nxt[i] = diff[i][PWM_BITS] ? '0
                                          : diff[i][PWM_BITS-1:0];
      if (PATTERN_VALID && PATTERN[i])
        target_nxt[i] = MAX;
    end
  end

  // pattern capture and target update
  always_ff @(posedge CLK) begin
    if (RST) begin
      pat <= '0;
      for (int i = 0; i < NUM_LEDS; i++)
        target[i] <= '0;
    end else begin
      if (PATTERN_VALID)
        pat <= PATTERN;
      for (int i = 0; i < NUM_LEDS; i++)
        target[i] <= target_nxt[i];
    end
  end

  // active levels only change on the frame wrap,
  // so a PWM period is never cut short
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_LEDS; i++)
        active[i] <= '0;
    end else if (wrap) begin
      for (int i = 0; i < NUM_LEDS; i++)
        active[i] <= target[i];
    end
  end

  // registered PWM outputs and frame strobe
  always_ff @(posedge CLK) begin
    if (RST) begin
      LED        <= '0;
      FRAME_TICK <= 1'b0;
    end else begin
      FRAME_TICK <= wrap;
      for (int i = 0; i < NUM_LEDS; i++)
        LED[i] <= ENABLE && (cnt < active[i]);
    end
  end

endmodule

// File: tb/tb_led_fade_pwm.sv
// tb_led_fade_pwm: directed frame-by-frame duty
// checks for the LED fade PWM block.
module tb_led_fade_pwm;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] PATTERN;
  logic       PATTERN_VALID;
  logic       ENABLE;
  logic [3:0] LED;
  logic       FRAME_TICK;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic            pv;
    logic            at_tick;
    logic [3:0]      pat;
    logic [3:0][3:0] duty;
  } vec_t;

  vec_t va [23];
  vec_t vb [10];

  led_fade_pwm #(
    .NUM_LEDS    (4),
    .PWM_BITS    (4),
    .DECAY_FRAMES(2),
    .DECAY_STEP  (4)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .PATTERN      (PATTERN),
    .PATTERN_VALID(PATTERN_VALID),
    .ENABLE       (ENABLE),
    .LED          (LED),
    .FRAME_TICK   (FRAME_TICK)
  );

  always #5 CLK = ~CLK;

  function automatic vec_t mk(
    input logic pv, input logic at,
    input logic [3:0] pat,
    input int d0, input int d1,
    input int d2, input int d3);
    vec_t r;
    r.pv      = pv;
    r.at_tick = at;
    r.pat     = pat;
    r.duty[0] = 4'(d0);
    r.duty[1] = 4'(d1);
    r.duty[2] = 4'(d2);
    r.duty[3] = 4'(d3);
    return r;
  endfunction

  task automatic check(input bit ok, input string nm,
                       input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // count cycles to the next FRAME_TICK (bounded)
  task automatic wait_tick(input string nm, input int exp);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!FRAME_TICK && k < 40);
    check(k == exp, nm, k, exp);
  endtask

  // one 15-cycle window starting after a FRAME_TICK
  task automatic run_frame(input vec_t v, input string tag);
    int d [4];
    int ftbad;
    d     = '{default: 0};
    ftbad = 0;
    for (int s = 0; s < 15; s++) begin
      if (v.pv && ((s == 0 && !v.at_tick) ||
                   (s == 14 && v.at_tick))) begin
        PATTERN       = v.pat;
        PATTERN_VALID = 1'b1;
      end
      step();
      PATTERN_VALID = 1'b0;
      for (int i = 0; i < 4; i++)
        d[i] += int'(LED[i]);
      if (FRAME_TICK !== (s == 14))
        ftbad++;
    end
    for (int i = 0; i < 4; i++)
      check(d[i] == int'(v.duty[i]),
            $sformatf("%s_duty%0d", tag, i),
            d[i], int'(v.duty[i]));
    check(ftbad == 0, {tag, "_ftick"}, ftbad, 0);
  endtask

  initial begin
    int bad;

    // frames W1..W23
    va[0]  = mk(0, 0, 4'b0000,  0,  0,  0, 0);
    va[1]  = mk(1, 0, 4'b0001,  0,  0,  0, 0);
    va[2]  = mk(0, 0, 4'b0000, 15,  0,  0, 0);
    va[3]  = mk(1, 0, 4'b0010, 15,  0,  0, 0);
    va[4]  = mk(0, 0, 4'b0000, 15, 15,  0, 0);
    va[5]  = mk(0, 0, 4'b0000, 15, 15,  0, 0);
    va[6]  = mk(0, 0, 4'b0000, 11, 15,  0, 0);
    va[7]  = mk(0, 0, 4'b0000, 11, 15,  0, 0);
    va[8]  = mk(0, 0, 4'b0000,  7, 15,  0, 0);
    va[9]  = mk(0, 0, 4'b0000,  7, 15,  0, 0);
    va[10] = mk(0, 0, 4'b0000,  3, 15,  0, 0);
    va[11] = mk(0, 0, 4'b0000,  3, 15,  0, 0);
    va[12] = mk(1, 0, 4'b0110,  0, 15,  0, 0);
    va[13] = mk(1, 0, 4'b0010,  0, 15, 15, 0);
    va[14] = mk(0, 0, 4'b0000,  0, 15, 15, 0);
    va[15] = mk(0, 0, 4'b0000,  0, 15, 15, 0);
    va[16] = mk(0, 0, 4'b0000,  0, 15, 11, 0);
    va[17] = mk(0, 0, 4'b0000,  0, 15, 11, 0);
    va[18] = mk(0, 0, 4'b0000,  0, 15,  7, 0);
    va[19] = mk(0, 0, 4'b0000,  0, 15,  7, 0);
    va[20] = mk(1, 1, 4'b0100,  0, 15,  3, 0);
    va[21] = mk(0, 0, 4'b0000,  0, 15,  3, 0);
    va[22] = mk(0, 0, 4'b0000,  0, 11, 15, 0);

    // frames W27..W36
    vb[0]  = mk(0, 0, 4'b0000,  0,  3, 15, 0);
    vb[1]  = mk(0, 0, 4'b0000,  0,  3, 15, 0);
    vb[2]  = mk(1, 0, 4'b0011,  0,  0, 15, 0);
    vb[3]  = mk(0, 0, 4'b0000, 15, 15, 15, 0);
    vb[4]  = mk(0, 0, 4'b0000, 15, 15, 11, 0);
    vb[5]  = mk(0, 0, 4'b0000, 15, 15, 11, 0);
    vb[6]  = mk(0, 0, 4'b0000, 15, 15,  7, 0);
    vb[7]  = mk(0, 0, 4'b0000, 15, 15,  7, 0);
    vb[8]  = mk(0, 0, 4'b0000, 15, 15,  3, 0);
    vb[9]  = mk(0, 0, 4'b0000, 15, 15,  3, 0);

    RST           = 1'b1;
    PATTERN       = 4'b0000;
    PATTERN_VALID = 1'b0;
    ENABLE        = 1'b1;

    repeat (3) step();
    check(LED == 4'b0000, "rst_led", int'(LED), 0);
    check(FRAME_TICK == 1'b0, "rst_ftick",
          int'(FRAME_TICK), 0);
    RST = 1'b0;

    wait_tick("first_ftick", 15);

    for (int f = 0; f < 23; f++)
      run_frame(va[f], $sformatf("wa%0d", f + 1));

    // disable for 40 cycles in the middle of a fade
    ENABLE = 1'b0;
    step();
    check(LED == 4'b0000, "en_off_led", int'(LED), 0);
    bad = 0;
    for (int k = 0; k < 39; k++) begin
      step();
      if (LED != 4'b0000)
        bad++;
    end
    check(bad == 0, "en_off_hold", bad, 0);
    ENABLE = 1'b1;
    step();
    check(LED == 4'b0100, "reen_led", int'(LED), 4);
    repeat (3) step();
    step();
    check(FRAME_TICK == 1'b1, "reen_ftick",
          int'(FRAME_TICK), 1);

    for (int f = 0; f < 10; f++)
      run_frame(vb[f], $sformatf("wb%0d", f + 27));

    // reset pulse mid-frame at cnt==7
    repeat (7) step();
    check(LED == 4'b0011, "pre_rst_led", int'(LED), 3);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check(LED == 4'b0000, "mid_rst_led", int'(LED), 0);
    check(FRAME_TICK == 1'b0, "mid_rst_ftick",
          int'(FRAME_TICK), 0);
    wait_tick("post_rst_ftick", 15);
    run_frame(va[0], "pr1");
    run_frame(va[0], "pr2");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
